// File: rtl/clz_iter_unit_if.sv
// rtl/clz_iter_unit_if.sv - handshake bundle for the iterative clz/clo unit
//
// Purpose: groups the request/result signals of clz_iter_unit.
// Ports (signals):
//   start    : request, driven by master
//   mode     : 0 = leading zeros, 1 = leading ones, driven by master
//   data_in  : operand [WIDTH-1:0], driven by master
//   busy     : scan in progress, driven by slave
//   done     : one-cycle result-valid pulse, driven by slave
//   data_out : result [OUT_W-1:0], driven by slave
interface clz_iter_unit_if #(
  parameter int WIDTH = 32,
  parameter int OUT_W = 32
) ();
  logic             start;
  logic             mode;
  logic [WIDTH-1:0] data_in;
  logic             busy;
  logic             done;
  logic [OUT_W-1:0] data_out;

  modport master (
    output start, mode, data_in,
    input  busy, done, data_out
  );

  modport slave (
    input  start, mode, data_in,
    output busy, done, data_out
  );
endinterface

// File: rtl/clz_iter_unit.sv
// rtl/clz_iter_unit.sv - iterative count-leading-zeros/ones unit, CHUNK bits per cycle
//
// Purpose: scans the operand MSB-first one CHUNK-bit slice per clock and stops
// on the first slice holding a significant bit. Leading-ones mode inverts the
// operand on capture so the same zero-scan datapath serves both.
// Ports:
//   clk : clock, rising edge
//   rst : synchronous active-high reset
//   bus : clz_iter_unit_if slave (start/mode/data_in in, busy/done/data_out out)
module clz_iter_unit #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8,
  parameter int OUT_W = 32
) (
  input  logic            clk,
  input  logic            rst,
  clz_iter_unit_if.slave  bus
);

  localparam int NSLICE = WIDTH / CHUNK;
  localparam int CW     = $clog2(WIDTH) + 1;
  // One extra bit keeps the index non-degenerate when a single slice covers WIDTH.
  localparam int IW     = $clog2(NSLICE) + 1;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [WIDTH-1:0]  sh;
  logic [CW-1:0]     cnt;
  logic [CW-1:0]     lz;
  logic [IW-1:0]     idx;
  logic [CHUNK-1:0]  slice;
  logic              slice_zero;
  logic              last_slice;
  logic              accept;

  assign slice      = sh[WIDTH-1 -: CHUNK];
  assign slice_zero = (slice == '0);
  assign last_slice = (idx == IW'(NSLICE - 1));
  // DONE accepts a new request exactly like IDLE, giving back-to-back operation.
  assign accept     = bus.start && ((state == IDLE) || (state == DONE));

  // Leading zeros inside the current slice; the highest set bit is visited
  // last, so it decides the value. Only used when the slice is nonzero.
  always_comb begin
    lz = '0;
    for (int i = 0; i < CHUNK; i++) begin
      if (slice[i]) lz = CW'(CHUNK - 1 - i);
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = SCAN;
      SCAN:    if (!slice_zero || last_slice) state_nxt = DONE;
      DONE:    state_nxt = accept ? SCAN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    bus.busy = (state == SCAN);
    bus.done = (state == DONE);
  end

  // Scan datapath and result register
  always_ff @(posedge clk) begin
    if (rst) begin
      sh           <= '0;
      cnt          <= '0;
      idx          <= '0;
      bus.data_out <= '0;
    end else if (accept) begin
      sh  <= bus.mode ? ~bus.data_in : bus.data_in;
      cnt <= '0;
      idx <= '0;
    end else if (state == SCAN) begin
      if (!slice_zero) begin
        bus.data_out <= OUT_W'(cnt + lz);
      end else if (last_slice) begin
        bus.data_out <= OUT_W'(WIDTH);
      end else begin
        cnt <= cnt + CW'(CHUNK);
        sh  <= sh << CHUNK;
        idx <= idx + IW'(1);
      end
    end
  end

endmodule
